// File: rtl/flapjack_console_if.sv
// Producer handshake and screen write bus for the flapjack console.
// The slave side is the console; the master side is producers plus the screen.
interface flapjack_console_if #(
    parameter int N_CH  = 2,
    parameter int X_W   = 7,
    parameter int Y_W   = 6,
    parameter int CHR_W = 9
);
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*CHR_W-1:0] in_chr;
    logic [N_CH-1:0]       in_ready;
    logic [X_W-1:0]        char_x;
    logic [Y_W-1:0]        char_y;
    logic [CHR_W-1:0]      char_chr;
    logic                  char_str;
    logic                  busy;

    modport master (
        output in_valid, in_chr,
        input  in_ready, char_x, char_y, char_chr, char_str, busy
    );

    modport slave (
        input  in_valid, in_chr,
        output in_ready, char_x, char_y, char_chr, char_str, busy
    );
endinterface

// File: rtl/flapjack_console.sv
// Multi-channel text console front end: round-robin producer arbitration,
// per-channel cursors confined to row bands, and window clear sequencing.
module flapjack_console #(
    parameter int             N_CH      = 2,
    parameter int             COLS      = 80,
    parameter int             ROWS      = 30,
    parameter int             X_W       = 7,
    parameter int             Y_W       = 6,
    parameter int             CHR_W     = 9,
    parameter logic [CHR_W-1:0] BLANK_CHR = CHR_W'(9'h020)
) (
    input logic clk_sys,
    input logic btn_rst_n,
    flapjack_console_if.slave bus
);
    localparam int WIN   = ROWS / N_CH;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [X_W-1:0] LAST_X = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] WIN_M1 = Y_W'(WIN - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [X_W-1:0]   cx_q [N_CH];
    logic [X_W-1:0]   cx_d [N_CH];
    logic [Y_W-1:0]   cy_q [N_CH];
    logic [Y_W-1:0]   cy_d [N_CH];
    logic [PTR_W-1:0] clr_ch_q, clr_ch_d;
    logic [X_W-1:0]   clr_x_q, clr_x_d;
    logic [Y_W-1:0]   clr_y_q, clr_y_d;
    logic             str_q, str_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CHR_W-1:0] chr_q, chr_d;
    logic             busy_q, busy_d;

    logic             gnt_vld, acc;
    int               gidx;
    logic [CHR_W-1:0] acc_chr;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y, top, ctop;
    logic             is_lf, is_cr, is_ff;
    logic             upd;
    int               upd_ch;
    logic [X_W-1:0]   nx;
    logic [Y_W-1:0]   ny;

    // Advance a row by one, wrapping back to the window top after its last row.
    function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W-1:0] y,
                                              input logic [Y_W-1:0] t);
        return (y == t + WIN_M1) ? t : y + 1'b1;
    endfunction

    // Round-robin search from rr_q; the nearest valid channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gidx    = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bus.in_valid[(int'(rr_q) + k) % N_CH]) begin
                gnt_vld = 1'b1;
                gidx    = (int'(rr_q) + k) % N_CH;
            end
        end
    end

    // Grant decode: ready, accepted code and the granted channel's cursor.
    always_comb begin
        acc     = gnt_vld && (state_q == IDLE) && btn_rst_n;
        acc_chr = '0;
        sel_x   = '0;
        sel_y   = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.in_ready[i] = acc && (i == gidx);
            if (i == gidx) begin
                acc_chr = bus.in_chr[i*CHR_W +: CHR_W];
                sel_x   = cx_q[i];
                sel_y   = cy_q[i];
            end
        end
        top   = Y_W'(gidx * WIN);
        ctop  = Y_W'(int'(clr_ch_q) * WIN);
        is_lf = (acc_chr == CHR_W'(9'h00A));
        is_cr = (acc_chr == CHR_W'(9'h00D));
        is_ff = (acc_chr == CHR_W'(9'h00C));
    end

    // Next-state: character handling in IDLE, raster blank fill in CLEAR.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        clr_ch_d = clr_ch_q;
        clr_x_d  = clr_x_q;
        clr_y_d  = clr_y_q;
        str_d    = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        chr_d    = chr_q;
        busy_d   = busy_q;
        upd      = 1'b0;
        upd_ch   = 0;
        nx       = '0;
        ny       = '0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    rr_d   = PTR_W'((gidx + 1) % N_CH);
                    upd    = 1'b1;
                    upd_ch = gidx;
                    nx     = sel_x;
                    ny     = sel_y;
                    unique case (1'b1)
                        is_lf: begin
                            nx = '0;
                            ny = wrap_y(sel_y, top);
                        end
                        is_cr: nx = '0;
                        is_ff: begin
                            upd      = 1'b0;
                            state_d  = CLEAR;
                            busy_d   = 1'b1;
                            str_d    = 1'b1;
                            x_d      = '0;
                            y_d      = top;
                            chr_d    = BLANK_CHR;
                            clr_ch_d = PTR_W'(gidx);
                            clr_x_d  = '0;
                            clr_y_d  = top;
                        end
                        default: begin
                            str_d = 1'b1;
                            x_d   = sel_x;
                            y_d   = sel_y;
                            chr_d = acc_chr;
                            if (sel_x == LAST_X) begin
                                nx = '0;
                                ny = wrap_y(sel_y, top);
                            end else begin
                                nx = sel_x + 1'b1;
                            end
                        end
                    endcase
                end
            end
            CLEAR: begin
                if (clr_x_q == LAST_X && clr_y_q == ctop + WIN_M1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    upd     = 1'b1;
                    upd_ch  = int'(clr_ch_q);
                    nx      = '0;
                    ny      = ctop;
                end else begin
                    if (clr_x_q == LAST_X) begin
                        clr_x_d = '0;
                        clr_y_d = clr_y_q + 1'b1;
                    end else begin
                        clr_x_d = clr_x_q + 1'b1;
                    end
                    str_d = 1'b1;
                    x_d   = clr_x_d;
                    y_d   = clr_y_d;
                    chr_d = BLANK_CHR;
                end
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < N_CH; i++) begin
            if (upd && i == upd_ch) begin
                cx_d[i] = nx;
                cy_d[i] = ny;
            end
        end
    end

    // State, cursors and registered write bus.
    always_ff @(posedge clk_sys or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            clr_ch_q <= '0;
            clr_x_q  <= '0;
            clr_y_q  <= '0;
            str_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            chr_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= Y_W'(i * WIN);
            end
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            clr_ch_q <= clr_ch_d;
            clr_x_q  <= clr_x_d;
            clr_y_q  <= clr_y_d;
            str_q    <= str_d;
            x_q      <= x_d;
            y_q      <= y_d;
            chr_q    <= chr_d;
            busy_q   <= busy_d;
            for (int i = 0; i < N_CH; i++) begin
                cx_q[i] <= cx_d[i];
                cy_q[i] <= cy_d[i];
            end
        end
    end

    assign bus.char_str = str_q;
    assign bus.char_x   = x_q;
    assign bus.char_y   = y_q;
    assign bus.char_chr = chr_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_flapjack_console.sv
// Directed bench for flapjack_console: vector table plus sequences for
// window fill, arbitration, window clear and reset during clear.
module tb_flapjack_console;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    flapjack_console_if bus ();

    flapjack_console dut (
        .clk_sys   (clk),
        .btn_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [8:0] c;
        logic       s;
        int         x;
        int         y;
    } vec_t;

    vec_t       tbl [11];
    logic       o_s;
    logic [6:0] o_x;
    logic [5:0] o_y;
    logic [8:0] o_c;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int ch, input logic [8:0] c);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = '0;
        bus.in_valid[ch] = 1'b1;
        bus.in_chr[ch*9 +: 9] = c;
        #1;
        while (!bus.in_ready[ch] && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ch %0d got no ready expected ready", ch);
        end
        @(posedge clk);
        #1;
        bus.in_valid = '0;
        o_s = bus.char_str;
        o_x = bus.char_x;
        o_y = bus.char_y;
        o_c = bus.char_chr;
    endtask

    task automatic write_at(input string name, input int ch,
                            input logic [8:0] c, input int x, input int y);
        send(ch, c);
        chk({name, "_str"}, o_s, 1);
        chk({name, "_x"}, o_x, x);
        chk({name, "_y"}, o_y, y);
        chk({name, "_chr"}, o_c, c);
    endtask

    task automatic ctrl(input string name, input int ch, input logic [8:0] c);
        send(ch, c);
        chk({name, "_nostr"}, o_s, 0);
    endtask

    initial begin
        int mx;
        int my;
        int g;
        logic ok;

        checks = 0;
        errors = 0;
        tbl[0]  = '{0, 9'h041, 1'b1, 0, 0};
        tbl[1]  = '{0, 9'h042, 1'b1, 1, 0};
        tbl[2]  = '{1, 9'h043, 1'b1, 0, 15};
        tbl[3]  = '{1, 9'h00D, 1'b0, 0, 0};
        tbl[4]  = '{1, 9'h044, 1'b1, 0, 15};
        tbl[5]  = '{1, 9'h00A, 1'b0, 0, 0};
        tbl[6]  = '{1, 9'h045, 1'b1, 0, 16};
        tbl[7]  = '{0, 9'h0FF, 1'b1, 2, 0};
        tbl[8]  = '{0, 9'h1AB, 1'b1, 3, 0};
        tbl[9]  = '{0, 9'h00D, 1'b0, 0, 0};
        tbl[10] = '{0, 9'h046, 1'b1, 0, 0};

        rst_n = 1'b0;
        bus.in_valid = 2'b11;
        bus.in_chr = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_str", bus.char_str, 0);
        chk("rst_x", bus.char_x, 0);
        chk("rst_y", bus.char_y, 0);
        chk("rst_chr", bus.char_chr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        bus.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].ch, tbl[i].c);
            chk($sformatf("vec%0d_str", i), o_s, tbl[i].s);
            if (tbl[i].s) begin
                chk($sformatf("vec%0d_x", i), o_x, tbl[i].x);
                chk($sformatf("vec%0d_y", i), o_y, tbl[i].y);
                chk($sformatf("vec%0d_chr", i), o_c, tbl[i].c);
            end
        end

        ctrl("fill_cr", 0, 9'h00D);
        mx = 0;
        my = 0;
        ok = 1'b1;
        for (int n = 0; n < 80 + 1 + 1119; n++) begin
            send(0, 9'(9'h030 + n % 10));
            if (o_s !== 1'b1 || o_x !== 7'(mx) || o_y !== 6'(my)) ok = 1'b0;
            if (n == 80) begin
                chk("row_wrap_x", o_x, 0);
                chk("row_wrap_y", o_y, 1);
            end
            mx++;
            if (mx == 80) begin
                mx = 0;
                my = (my == 14) ? 0 : my + 1;
            end
        end
        chk("fill_all_cells", ok, 1);
        write_at("win_wrap", 0, 9'h047, 0, 0);

        @(negedge clk);
        bus.in_valid = 2'b11;
        bus.in_chr = {9'h051, 9'h050};
        for (int k = 0; k < 4; k++) begin
            g = (1 + k) % 2;
            #1;
            chk("rr_ready", bus.in_ready, 1 << g);
            @(posedge clk);
            #1;
            chk("rr_chr", bus.char_chr, (g == 1) ? 9'h051 : 9'h050);
            chk("rr_y", bus.char_y, (g == 1) ? 16 : 0);
            chk("rr_x", bus.char_x, 1 + k / 2);
            @(negedge clk);
        end
        bus.in_valid = '0;

        send(1, 9'h00C);
        ok = (o_s === 1'b1) && (o_x === 7'd0) && (o_y === 6'd15)
             && (o_c === 9'h020) && (bus.busy === 1'b1);
        chk("clr_first", ok, 1);
        bus.in_valid = 2'b11;
        bus.in_chr = {9'h061, 9'h060};
        for (int k = 1; k < 1200; k++) begin
            @(posedge clk);
            #1;
            ok = (bus.char_str === 1'b1) && (bus.char_x === 7'(k % 80))
                 && (bus.char_y === 6'(15 + k / 80))
                 && (bus.char_chr === 9'h020) && (bus.busy === 1'b1)
                 && (bus.in_ready === 2'b00);
            chk($sformatf("clr_cell%0d", k), ok, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = '0;
        chk("clr_done_busy", bus.busy, 0);
        chk("clr_done_str", bus.char_str, 0);
        write_at("clr_home", 1, 9'h041, 0, 15);
        write_at("clr_other", 0, 9'h041, 3, 0);

        for (int k = 0; k < 3; k++) ctrl("lf_down", 0, 9'h00A);
        for (int k = 0; k < 5; k++) write_at("to53", 0, 9'h052, k, 3);
        ctrl("cr", 0, 9'h00D);
        write_at("after_cr", 0, 9'h048, 0, 3);
        for (int k = 0; k < 11; k++) ctrl("lf_run", 0, 9'h00A);
        ctrl("lf_row14", 0, 9'h00A);
        write_at("lf_wrap", 0, 9'h049, 0, 0);

        send(1, 9'h00C);
        chk("clr2_busy", bus.busy, 1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_str", bus.char_str, 0);
        chk("mid_rst_x", bus.char_x, 0);
        chk("mid_rst_y", bus.char_y, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_str", bus.char_str, 0);
        chk("post_rst_busy", bus.busy, 0);
        write_at("post_rst_ch1", 1, 9'h041, 0, 15);
        write_at("post_rst_ch0", 0, 9'h041, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
